// File: rtl/zx_raster_timing.sv
// Raster counters, blanking/sync, border, flash phase and frame/line interrupts
// for Pentagon, 48K, 128K and a parameter-defined custom machine timing.
module zx_raster_timing #(
    parameter int unsigned HC_W    = 9,
    parameter int unsigned VC_W    = 9,
    parameter int unsigned INT_LEN = 64,
    parameter int unsigned FLASH_W = 5,
    parameter int unsigned C_LINE  = 448,
    parameter int unsigned C_LINES = 312
) (
    input  logic            clk_sys,
    input  logic            nRESET,
    input  logic            ce_pix,
    input  logic [1:0]      mode,
    input  logic            line_int_ena,
    input  logic [VC_W-1:0] line_int_line,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic [1:0]      act_mode,
    output logic            hblank,
    output logic            hsync,
    output logic            vsync,
    output logic            border,
    output logic            frame_start,
    output logic            flash,
    output logic            frame_int,
    output logic            line_int,
    output logic            nINT
);
    localparam int unsigned CNT_W = 10;
    localparam logic [HC_W-1:0] HB_SET = HC_W'(312);

    if (HC_W < 9 || VC_W < 9) begin : g_chk_width
        $error("zx_raster_timing: HC_W and VC_W must be at least 9");
    end
    if (INT_LEN < 1 || INT_LEN > (1 << CNT_W) - 1) begin : g_chk_int_len
        $error("zx_raster_timing: INT_LEN must be in 1..1023");
    end
    if (FLASH_W < 1) begin : g_chk_flash
        $error("zx_raster_timing: FLASH_W must be at least 1");
    end
    if (C_LINE <= 424 || C_LINE > (1 << HC_W)) begin : g_chk_c_line
        $error("zx_raster_timing: C_LINE must be > 424 and <= 2**HC_W");
    end
    if (C_LINES <= 256 || C_LINES > (1 << VC_W)) begin : g_chk_c_lines
        $error("zx_raster_timing: C_LINES must be > 256 and <= 2**VC_W");
    end

    logic [HC_W-1:0]    hc_q, hc_d;
    logic [VC_W-1:0]    vc_q, vc_d;
    logic [1:0]         act_mode_q, act_mode_d;
    logic [FLASH_W-1:0] flash_q, flash_d;
    logic               hblank_q, hblank_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic               fstart_q, fstart_d, nint_q, nint_d;
    logic               fint_q, fint_d, lint_q, lint_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d, lcnt_q, lcnt_d;

    logic [HC_W-1:0]    line_last, hb_clr, hs_set, hs_clr, int_hc;
    logic [VC_W-1:0]    lines_last, vs_set, vs_clr, int_vc;
    logic               hc_end, vc_end;

    // Compare positions for the timing in effect; custom shares the 48K positions.
    always_comb begin : timing_sel
        line_last  = HC_W'(448 - 1);
        lines_last = VC_W'(312 - 1);
        hb_clr     = HC_W'(416);
        hs_set     = HC_W'(336);
        hs_clr     = HC_W'(368);
        vs_set     = VC_W'(240);
        vs_clr     = VC_W'(244);
        int_vc     = VC_W'(248);
        int_hc     = HC_W'(4);
        case (act_mode_q)
            2'd0: begin
                lines_last = VC_W'(320 - 1);
                hb_clr     = HC_W'(420);
                hs_set     = HC_W'(338);
                hs_clr     = HC_W'(370);
                vs_set     = VC_W'(248);
                vs_clr     = VC_W'(256);
                int_vc     = VC_W'(239);
                int_hc     = HC_W'(326);
            end
            2'd2: begin
                line_last  = HC_W'(456 - 1);
                lines_last = VC_W'(311 - 1);
                hb_clr     = HC_W'(424);
                hs_set     = HC_W'(340);
                hs_clr     = HC_W'(372);
                int_hc     = HC_W'(8);
            end
            2'd3: begin
                line_last  = HC_W'(C_LINE - 1);
                lines_last = VC_W'(C_LINES - 1);
            end
            default: ;
        endcase
    end

    assign hc_end = (hc_q == line_last);
    assign vc_end = (vc_q == lines_last);

    // Vertical events are evaluated on the line-advance tick, like the counter.
    always_comb begin : next_state
        hc_d       = hc_q;
        vc_d       = vc_q;
        act_mode_d = act_mode_q;
        flash_d    = flash_q;
        hblank_d   = hblank_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        fstart_d   = fstart_q;
        fint_d     = fint_q;
        fcnt_d     = fcnt_q;
        lint_d     = lint_q;
        lcnt_d     = lcnt_q;
        if (ce_pix) begin
            if (hc_end) begin
                hc_d = '0;
                if (vc_end) begin
                    vc_d       = '0;
                    flash_d    = flash_q + FLASH_W'(1);
                    act_mode_d = mode;
                end else begin
                    vc_d = vc_q + VC_W'(1);
                end
                if (vc_q == vs_set) begin
                    vsync_d = 1'b1;
                end else if (vc_q == vs_clr) begin
                    vsync_d = 1'b0;
                end
            end else begin
                hc_d = hc_q + HC_W'(1);
            end

            if (hc_q == HB_SET) begin
                hblank_d = 1'b1;
            end else if (hc_q == hb_clr) begin
                hblank_d = 1'b0;
            end
            if (hc_q == hs_set) begin
                hsync_d = 1'b1;
            end else if (hc_q == hs_clr) begin
                hsync_d = 1'b0;
            end
            fstart_d = (hc_q == '0) && (vc_q == '0);

            if (fint_q) begin
                if (fcnt_q == '0) fint_d = 1'b0;
                else              fcnt_d = fcnt_q - CNT_W'(1);
            end else if (hc_q == int_hc && vc_q == int_vc) begin
                fint_d = 1'b1;
                fcnt_d = CNT_W'(INT_LEN - 1);
            end

            if (lint_q) begin
                if (lcnt_q == '0) lint_d = 1'b0;
                else              lcnt_d = lcnt_q - CNT_W'(1);
            end else if (line_int_ena && hc_q == '0 && vc_q == line_int_line) begin
                lint_d = 1'b1;
                lcnt_d = CNT_W'(INT_LEN - 1);
            end
        end
        nint_d = ~(fint_d | lint_d);
    end

    always_ff @(posedge clk_sys) begin : state_reg
        if (!nRESET) begin
            hc_q       <= '0;
            vc_q       <= '0;
            act_mode_q <= mode;
            flash_q    <= '0;
            hblank_q   <= 1'b1;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            fstart_q   <= 1'b0;
            fint_q     <= 1'b0;
            fcnt_q     <= '0;
            lint_q     <= 1'b0;
            lcnt_q     <= '0;
            nint_q     <= 1'b1;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            act_mode_q <= act_mode_d;
            flash_q    <= flash_d;
            hblank_q   <= hblank_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fstart_q   <= fstart_d;
            fint_q     <= fint_d;
            fcnt_q     <= fcnt_d;
            lint_q     <= lint_d;
            lcnt_q     <= lcnt_d;
            nint_q     <= nint_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign act_mode    = act_mode_q;
    assign hblank      = hblank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fstart_q;
    assign flash       = flash_q[FLASH_W-1];
    assign frame_int   = fint_q;
    assign line_int    = lint_q;
    assign nINT        = nint_q;
    assign border      = (vc_q >= VC_W'(192) && vc_q <= VC_W'(255)) || vc_q[8] || hc_q[8];

endmodule

// File: tb/tb_zx_raster_timing.sv
// Bench for zx_raster_timing: frame-position reference model checked every clock,
// plus directed point checks at the interrupt, sync and wrap positions.
module tb_zx_raster_timing;
    localparam int INT_LEN_P = 64;
    localparam int FLASH_W_P = 1;
    localparam int C_LINE_P  = 430;
    localparam int C_LINES_P = 300;

    logic       clk_sys, nRESET, ce_pix, line_int_ena;
    logic [1:0] mode, act_mode;
    logic [8:0] line_int_line, hc, vc;
    logic       hblank, hsync, vsync, border, frame_start, flash, frame_int, line_int, nINT;

    zx_raster_timing #(
        .HC_W(9), .VC_W(9), .INT_LEN(INT_LEN_P), .FLASH_W(FLASH_W_P),
        .C_LINE(C_LINE_P), .C_LINES(C_LINES_P)
    ) dut (
        .clk_sys(clk_sys), .nRESET(nRESET), .ce_pix(ce_pix), .mode(mode),
        .line_int_ena(line_int_ena), .line_int_line(line_int_line),
        .hc(hc), .vc(vc), .act_mode(act_mode), .hblank(hblank), .hsync(hsync),
        .vsync(vsync), .border(border), .frame_start(frame_start), .flash(flash),
        .frame_int(frame_int), .line_int(line_int), .nINT(nINT)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: timing in effect, ticks into the frame, frames and ticks since
    // reset, and the tick at which each interrupt rose (-1 = none).
    int m_mode, m_pos, m_frames, m_ticks, f_rise, l_rise;

    function automatic int t_line(input int m);
        case (m) 0, 1: return 448; 2: return 456; default: return C_LINE_P; endcase
    endfunction
    function automatic int t_lines(input int m);
        case (m) 0: return 320; 1: return 312; 2: return 311; default: return C_LINES_P; endcase
    endfunction
    function automatic int t_hb_clr(input int m);
        case (m) 0: return 420; 2: return 424; default: return 416; endcase
    endfunction
    function automatic int t_hs_set(input int m);
        case (m) 0: return 338; 2: return 340; default: return 336; endcase
    endfunction
    function automatic int t_hs_clr(input int m);
        case (m) 0: return 370; 2: return 372; default: return 368; endcase
    endfunction
    function automatic int t_vs_set(input int m);
        return (m == 0) ? 248 : 240;
    endfunction
    function automatic int t_vs_clr(input int m);
        return (m == 0) ? 256 : 244;
    endfunction
    function automatic int t_int_vc(input int m);
        return (m == 0) ? 239 : 248;
    endfunction
    function automatic int t_int_hc(input int m);
        case (m) 0: return 326; 2: return 8; default: return 4; endcase
    endfunction
    function automatic bit pulse_on(input int rise);
        return rise >= 0 && (m_ticks - rise) < INT_LEN_P;
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (frame %0d pos %0d)",
                   tag, obs, exp, m_frames, m_pos);
        end
    endtask

    task automatic check_all();
        int L, hx, vx;
        bit fresh, fi, li;
        L     = t_line(m_mode);
        hx    = m_pos % L;
        vx    = m_pos / L;
        fresh = (m_frames == 0) && (vx == 0);
        fi    = pulse_on(f_rise);
        li    = pulse_on(l_rise);
        check1("hc", 32'(hc), hx);
        check1("vc", 32'(vc), vx);
        check1("act_mode", 32'(act_mode), m_mode);
        check1("hblank", 32'(hblank),
               32'((hx > 312 && hx <= t_hb_clr(m_mode)) || (fresh && hx <= t_hb_clr(m_mode))));
        check1("hsync", 32'(hsync), 32'(hx > t_hs_set(m_mode) && hx <= t_hs_clr(m_mode)));
        check1("vsync", 32'(vsync), 32'(vx > t_vs_set(m_mode) && vx <= t_vs_clr(m_mode)));
        check1("border", 32'(border), 32'((vx >= 192 && vx <= 255) || vx >= 256 || hx >= 256));
        check1("frame_start", 32'(frame_start), 32'(hx == 1 && vx == 0));
        check1("flash", 32'(flash), (m_frames >> (FLASH_W_P - 1)) & 1);
        check1("frame_int", 32'(frame_int), 32'(fi));
        check1("line_int", 32'(line_int), 32'(li));
        check1("nINT", 32'(nINT), 32'(!(fi || li)));
    endtask

    task automatic model_tick();
        int L, hx, vx;
        L  = t_line(m_mode);
        hx = m_pos % L;
        vx = m_pos / L;
        if (hx == t_int_hc(m_mode) && vx == t_int_vc(m_mode) && !pulse_on(f_rise))
            f_rise = m_ticks + 1;
        if (line_int_ena && hx == 0 && vx == int'(line_int_line) && !pulse_on(l_rise))
            l_rise = m_ticks + 1;
        m_ticks++;
        m_pos++;
        if (m_pos == L * t_lines(m_mode)) begin
            m_pos = 0;
            m_frames++;
            m_mode = int'(mode);
        end
    endtask

    task automatic clk_cycle(input bit ce);
        ce_pix = ce;
        if (ce) model_tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_all();
    endtask

    task automatic reset_cycle(input bit ce);
        nRESET   = 1'b0;
        ce_pix   = ce;
        m_mode   = int'(mode);
        m_pos    = 0;
        m_frames = 0;
        m_ticks  = 0;
        f_rise   = -1;
        l_rise   = -1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_all();
    endtask

    // One pixel tick, occasionally preceded by an idle clock with ce_pix low.
    task automatic tick();
        if ($urandom_range(0, 15) == 0) clk_cycle(1'b0);
        clk_cycle(1'b1);
    endtask

    initial begin
        nRESET        = 1'b0;
        ce_pix        = 1'b0;
        mode          = 2'd1;
        line_int_ena  = 1'b1;
        line_int_line = 9'd248;

        // 48K frame with line INT at 248; mode request randomised, then 2 from vc 100.
        for (int i = 0; i < 3; i++) reset_cycle(1'b1);
        check1("rst_hc", 32'(hc), 32'd0);
        check1("rst_hblank", 32'(hblank), 32'd1);
        check1("rst_nINT", 32'(nINT), 32'd1);
        check1("rst_act_mode", 32'(act_mode), 32'd1);
        nRESET = 1'b1;
        while (m_frames == 0) begin
            if (m_pos < 100 * 448) begin
                if (m_pos % 997 == 0) mode = 2'($urandom_range(0, 3));
            end else begin
                mode = 2'd2;
            end
            if (m_pos == 248 * 448 + 20) line_int_ena = 1'b0;
            tick();
            if (m_pos == 248 * 448) check1("A_li_pre", 32'(line_int), 32'd0);
            if (m_pos == 248 * 448 + 1) begin
                check1("A_li_rise", 32'(line_int), 32'd1);
                check1("A_fi_pre", 32'(frame_int), 32'd0);
                check1("A_nINT_low", 32'(nINT), 32'd0);
            end
            if (m_pos == 248 * 448 + 5)  check1("A_fi_rise", 32'(frame_int), 32'd1);
            if (m_pos == 248 * 448 + 64) check1("A_li_held", 32'(line_int), 32'd1);
            if (m_pos == 248 * 448 + 65) begin
                check1("A_li_fall", 32'(line_int), 32'd0);
                check1("A_nINT_both", 32'(nINT), 32'd0);
            end
            if (m_pos == 248 * 448 + 68) check1("A_fi_held", 32'(frame_int), 32'd1);
            if (m_pos == 248 * 448 + 69) begin
                check1("A_fi_fall", 32'(frame_int), 32'd0);
                check1("A_nINT_high", 32'(nINT), 32'd1);
            end
        end
        check1("A_act_mode", 32'(act_mode), 32'd2);
        check1("A_flash", 32'(flash), 32'd1);

        // 128K frame, unreachable line INT, then reset inside the frame INT pulse.
        line_int_line = 9'd400;
        line_int_ena  = 1'b1;
        while (m_pos != 248 * 456 + 38) begin
            if (m_pos % 1500 == 0) mode = 2'($urandom_range(0, 3));
            tick();
            if (m_pos == 10 * 456 + 340) check1("B_hs_340", 32'(hsync), 32'd0);
            if (m_pos == 10 * 456 + 341) check1("B_hs_341", 32'(hsync), 32'd1);
            if (m_pos == 10 * 456 + 372) check1("B_hs_372", 32'(hsync), 32'd1);
            if (m_pos == 10 * 456 + 373) check1("B_hs_373", 32'(hsync), 32'd0);
            if (m_pos == 248 * 456 + 8) check1("B_fi_pre", 32'(frame_int), 32'd0);
            if (m_pos == 248 * 456 + 9) check1("B_nINT_fall", 32'(nINT), 32'd0);
        end
        check1("B_fi_active", 32'(frame_int), 32'd1);
        check1("B_no_li", 32'(line_int), 32'd0);
        mode = 2'd0;
        reset_cycle(1'b0);
        check1("R_fi_clr", 32'(frame_int), 32'd0);
        check1("R_nINT", 32'(nINT), 32'd1);
        check1("R_act_mode", 32'(act_mode), 32'd0);
        reset_cycle(1'b0);
        nRESET = 1'b1;

        // Pentagon from reset through INT and vsync.
        line_int_line = 9'($urandom_range(1, 200));
        while (m_pos != 257 * 448 + 3) begin
            tick();
            if (m_pos == int'(line_int_line) * 448 + 1) check1("C_li_rise", 32'(line_int), 32'd1);
            if (m_pos == 239 * 448 + 326) check1("C_fi_pre", 32'(frame_int), 32'd0);
            if (m_pos == 239 * 448 + 327) check1("C_fi_rise", 32'(frame_int), 32'd1);
            if (m_pos == 248 * 448 + 447) check1("C_vs_248", 32'(vsync), 32'd0);
            if (m_pos == 249 * 448)       check1("C_vs_249", 32'(vsync), 32'd1);
            if (m_pos == 256 * 448 + 447) check1("C_vs_256", 32'(vsync), 32'd1);
            if (m_pos == 257 * 448)       check1("C_vs_257", 32'(vsync), 32'd0);
        end

        // Custom timing: short lines of C_LINE_P pixels.
        mode = 2'd3;
        reset_cycle(1'b0);
        nRESET = 1'b1;
        while (m_pos < 3 * C_LINE_P + 10) begin
            tick();
            if (m_pos == C_LINE_P - 1) check1("D_hc_last", 32'(hc), 32'd429);
            if (m_pos == C_LINE_P) begin
                check1("D_hc_wrap", 32'(hc), 32'd0);
                check1("D_vc_inc", 32'(vc), 32'd1);
            end
            if (m_pos == C_LINE_P + 416) check1("D_hb_416", 32'(hblank), 32'd1);
            if (m_pos == C_LINE_P + 417) check1("D_hb_417", 32'(hblank), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
